// File: rtl/fm_demod_pkg.sv
// Shared types and stream field positions for the FM demodulator path.
package fm_demod_pkg;

  localparam int unsigned ANGLE_W = 16;
  localparam int unsigned MAG_W   = 16;
  localparam int unsigned AUDIO_W = 16;

  // Input beat field positions (CORDIC output: {angle, magnitude})
  localparam int unsigned IN_MAG_LSB   = 0;
  localparam int unsigned IN_ANGLE_LSB = 16;

  typedef logic [ANGLE_W-1:0]        angle_t;
  typedef logic [MAG_W-1:0]          mag_t;
  typedef logic signed [AUDIO_W-1:0] audio_t;

  // Input beat layout
  typedef struct packed {
    angle_t angle;
    mag_t   mag;
  } in_beat_t;

  // Output beat layout: [31:17] zero, [16] squelch, [15:0] audio
  typedef struct packed {
    logic [14:0] rsvd;
    logic        squelch;
    audio_t      audio;
  } out_beat_t;

endpackage

// File: rtl/fm_discriminator_decim_accum.sv
// Accumulate-and-dump decimator: sums DECIM samples (or fewer on flush).
module decim_accum
  import fm_demod_pkg::*;
#(
  parameter int unsigned DECIM = 8,
  parameter int unsigned ACC_W = AUDIO_W + $clog2(DECIM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    flush,
  input  audio_t                  din,
  output logic                    emit_c,
  output logic signed [ACC_W-1:0] sum_c
);

  localparam int unsigned LOG2  = $clog2(DECIM);
  localparam int unsigned CNT_W = (LOG2 > 0) ? LOG2 : 1;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        count_q, count_d;

  // Running sum including the current sample, and end-of-group detect
  always_comb begin
    sum_c  = acc_q + ACC_W'(din);
    emit_c = en && (flush || (count_q == CNT_W'(DECIM - 1)));
  end

  // Next-state: accumulate on each accepted sample, dump on emit
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    if (en) begin
      if (emit_c) begin
        acc_d   = '0;
        count_d = '0;
      end else begin
        acc_d   = sum_c;
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fm_discriminator.sv
// FM discriminator: phase differencing, squelch, decimation, AXIS output.
// Optional de-emphasis filter enabled by defining FM_DEEMPH_EN.
module fm_discriminator
  import fm_demod_pkg::*;
#(
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_DECIMATION           = 8,
  parameter int unsigned C_DEEMPH_SHIFT         = 3
) (
  input  logic                                    s00_axis_aclk,
  input  logic                                    s00_axis_areset,
  input  logic                                    s00_axis_tvalid,
  input  logic                                    s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]       s00_axis_tdata,
  input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0]   s00_axis_tstrb,
  output logic                                    s00_axis_tready,
  input  logic [MAG_W-1:0]                        squelch_threshold,
  input  logic                                    m00_axis_tready,
  output logic                                    m00_axis_tvalid,
  output logic                                    m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]       m00_axis_tdata,
  output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0]   m00_axis_tstrb
);

  localparam int unsigned LOG2  = $clog2(C_DECIMATION);
  localparam int unsigned ACC_W = AUDIO_W + LOG2;

  logic                    accept_c;
  logic                    emit_c;
  logic signed [ACC_W-1:0] sum_c;
  angle_t                  angle_c;
  mag_t                    mag_c;
  logic                    squelch_c;
  audio_t                  dphi_c;
  audio_t                  audio_c;
  audio_t                  out_c;

  angle_t    prev_angle_q, prev_angle_d;
  logic      have_prev_q, have_prev_d;
  logic      flag_q, flag_d;
  logic      tvalid_q, tvalid_d;
  logic      tlast_q, tlast_d;
  out_beat_t tdata_q, tdata_d;

  logic      unused_c;

  assign s00_axis_tready = !s00_axis_areset && (!tvalid_q || m00_axis_tready);
  assign accept_c        = s00_axis_tvalid && s00_axis_tready;

  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tdata  = C_M00_AXIS_TDATA_WIDTH'(tdata_q);
  assign m00_axis_tstrb  = '1;

  assign unused_c = ^{s00_axis_tstrb, s00_axis_tdata, 32'(C_DEEMPH_SHIFT)};

  decim_accum #(
    .DECIM (C_DECIMATION),
    .ACC_W (ACC_W)
  ) u_accum (
    .clk    (s00_axis_aclk),
    .rst    (s00_axis_areset),
    .en     (accept_c),
    .flush  (s00_axis_tlast),
    .din    (dphi_c),
    .emit_c (emit_c),
    .sum_c  (sum_c)
  );

  // Phase difference with squelch gating, and decimated audio scaling
  always_comb begin
    angle_c   = s00_axis_tdata[IN_ANGLE_LSB +: ANGLE_W];
    mag_c     = s00_axis_tdata[IN_MAG_LSB +: MAG_W];
    squelch_c = (mag_c < squelch_threshold);
    dphi_c    = '0;
    if (have_prev_q && !squelch_c) begin
      dphi_c = AUDIO_W'(angle_c - prev_angle_q);
    end
    audio_c = AUDIO_W'(sum_c >>> LOG2);
  end

`ifdef FM_DEEMPH_EN
  audio_t              y_q, y_d;
  logic signed [16:0]  deemph_diff_c;

  // First-order de-emphasis: y + ((audio - y) >>> shift)
  always_comb begin
    deemph_diff_c = 17'(audio_c) - 17'(y_q);
    out_c         = y_q + AUDIO_W'(deemph_diff_c >>> C_DEEMPH_SHIFT);
    y_d           = y_q;
    if (emit_c) begin
      y_d = out_c;
    end
  end

  // De-emphasis state register
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end
`else
  assign out_c = audio_c;
`endif

  // Next-state for phase tracking, squelch flag and output register
  always_comb begin
    prev_angle_d = prev_angle_q;
    have_prev_d  = have_prev_q;
    flag_d       = flag_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tdata_d      = tdata_q;
    if (tvalid_q && m00_axis_tready) begin
      tvalid_d = 1'b0;
    end
    if (accept_c) begin
      prev_angle_d = angle_c;
      have_prev_d  = 1'b1;
      flag_d       = flag_q | squelch_c;
    end
    if (emit_c) begin
      flag_d           = 1'b0;
      tvalid_d         = 1'b1;
      tlast_d          = s00_axis_tlast;
      tdata_d.rsvd     = '0;
      tdata_d.squelch  = flag_q | squelch_c;
      tdata_d.audio    = out_c;
      if (s00_axis_tlast) begin
        have_prev_d = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      prev_angle_q <= '0;
      have_prev_q  <= 1'b0;
      flag_q       <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
    end else begin
      prev_angle_q <= prev_angle_d;
      have_prev_q  <= have_prev_d;
      flag_q       <= flag_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
    end
  end

endmodule

// File: tb/tb_fm_discriminator.sv
// Scoreboard bench for fm_discriminator (C_DECIMATION = 8).
module tb_fm_discriminator;

  logic        clk = 1'b0;
  logic        areset;
  logic        s_tvalid;
  logic        s_tlast;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        s_tready;
  logic [15:0] thr;
  logic        m_tready;
  logic        m_tvalid;
  logic        m_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fm_discriminator #(
    .C_S00_AXIS_TDATA_WIDTH (32),
    .C_M00_AXIS_TDATA_WIDTH (32),
    .C_DECIMATION           (8),
    .C_DEEMPH_SHIFT         (3)
  ) dut (
    .s00_axis_aclk     (clk),
    .s00_axis_areset   (areset),
    .s00_axis_tvalid   (s_tvalid),
    .s00_axis_tlast    (s_tlast),
    .s00_axis_tdata    (s_tdata),
    .s00_axis_tstrb    (s_tstrb),
    .s00_axis_tready   (s_tready),
    .squelch_threshold (thr),
    .m00_axis_tready   (m_tready),
    .m00_axis_tvalid   (m_tvalid),
    .m00_axis_tlast    (m_tlast),
    .m00_axis_tdata    (m_tdata),
    .m00_axis_tstrb    (m_tstrb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pk(input int audio, input logic flag);
    return {15'b0, flag, 16'(audio)};
  endfunction

  task automatic push(input int audio, input logic flag, input logic last);
    exp_t e;
    e.data = pk(audio, flag);
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Monitor: compare each handshaken output against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (!areset && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %h want none", m_tdata);
      end else begin
        e = exp_q.pop_front();
        check("out_tdata", m_tdata, e.data);
        check("out_tlast", 32'(m_tlast), 32'(e.last));
      end
    end
  end

  task automatic send(input logic [15:0] ang, input logic [15:0] mag, input logic last);
    int n;
    s_tvalid = 1'b1;
    s_tdata  = {ang, mag};
    s_tlast  = last;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got tready=0 want 1");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic group(input logic [15:0] start, input logic [15:0] step, input int n,
                       input logic [15:0] mag, input logic last);
    logic [15:0] a;
    a = start;
    for (int k = 0; k < n; k++) begin
      send(a, mag, last && (k == n - 1));
      a = a + step;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  initial begin
    int n;
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    s_tstrb  = 4'hf;
    thr      = 16'd100;
    m_tready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tlast",  32'(m_tlast),  32'd0);
    check("rst_tdata",  m_tdata,       32'd0);
    check("rst_tready", 32'(s_tready), 32'd0);
    @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(s_tready), 32'd1);
    @(posedge clk);
    #1;

`ifdef FM_DEEMPH_EN
    // Raw decimated x = 7000, 8000, 8000 through y += (x - y) >>> 3
    push(875, 1'b0, 1'b0);
    push(1765, 1'b0, 1'b0);
    push(2544, 1'b0, 1'b1);
    group(16'd0, 16'd8000, 24, 16'd1000, 1'b1);
`else
    // Constant step: first group lacks a previous angle
    push(875, 1'b0, 1'b0);
    push(1000, 1'b0, 1'b0);
    push(1000, 1'b0, 1'b0);
    group(16'd0, 16'd1000, 24, 16'd1000, 1'b0);

    // Large steps crossing the +/-32768 boundary, tlast on the 8th beat
    push(12288, 1'b0, 1'b1);
    group(16'd23000 + 16'd12288, 16'h3000, 8, 16'd1000, 1'b1);
    push(10752, 1'b0, 1'b1);
    group(16'h7000, 16'h3000, 8, 16'd1000, 1'b1);

    // Negative steps
    push(-875, 1'b0, 1'b1);
    group(16'h0100, 16'hFC18, 8, 16'd1000, 1'b1);

    // Fully squelched group
    push(0, 1'b1, 1'b1);
    group(16'd0, 16'd5000, 8, 16'd50, 1'b1);

    // One squelched beat inside a group (mag 99)
    push(300, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) send(16'(k * 400), (k == 3) ? 16'd99 : 16'd1000, k == 7);
    s_tvalid = 1'b0;

    // mag 200, one beat exactly at threshold: not squelched
    push(262, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) send(16'(k * 300), (k == 2) ? 16'd100 : 16'd200, k == 7);
    s_tvalid = 1'b0;

    // Packet boundary on 3rd beat, then a group that starts with dphi 0
    push(200, 1'b0, 1'b1);
    group(16'd0, 16'd800, 3, 16'd1000, 1'b1);
    push(87, 1'b0, 1'b1);
    group(16'd5000, 16'd100, 8, 16'd1000, 1'b1);

    // Backpressure with an output pending
    @(posedge clk);
    #1 m_tready = 1'b0;
    push(875, 1'b0, 1'b0);
    push(1000, 1'b0, 1'b1);
    fork
      group(16'd0, 16'd1000, 16, 16'd1000, 1'b1);
      begin
        n = 0;
        while (!m_tvalid && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("bp_pending", 32'(m_tvalid), 32'd1);
        repeat (5) begin
          @(negedge clk);
          check("bp_s_tready", 32'(s_tready), 32'd0);
          check("bp_hold", m_tdata, pk(875, 1'b0));
        end
        @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join

    // Reset after 5 beats discards the partial group
    group(16'd0, 16'd1000, 5, 16'd1000, 1'b0);
    @(posedge clk);
    #1 areset = 1'b1;
    @(posedge clk);
    #1 areset = 1'b0;
    repeat (3) @(negedge clk);
    check("no_output_after_reset", 32'(m_tvalid), 32'd0);
    @(posedge clk);
    #1;
    push(437, 1'b0, 1'b1);
    group(16'd9000, 16'd500, 8, 16'd1000, 1'b1);
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    check("tstrb", 32'(m_tstrb), 32'hf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fm_discriminator.md
# fm_discriminator

- Sits directly downstream of the CORDIC magnitude/angle stage and upstream of the audio sink.
- Consumes the packed AXI-Stream {angle[31:16], magnitude[15:0]} beats and computes the phase difference between successive samples, which is the instantaneous frequency (FM demodulation).
- Gates samples below a magnitude threshold to zero (squelch).
- Accumulates and dumps C_DECIMATION samples and emits one signed 16-bit audio sample per group over AXI-Stream with backpressure.

## Interface
- C_S00_AXIS_TDATA_WIDTH, 32: input beat width; [31:16] angle (full circle = 65536), [15:0] unsigned magnitude.
- C_M00_AXIS_TDATA_WIDTH, 32: output beat width.
- C_DECIMATION, 8: samples per output; must be a power of two, 1..256.
- C_DEEMPH_SHIFT, 3: de-emphasis IIR coefficient shift; used only with FM_DEEMPH_EN.
- s00_axis_aclk  in  1: the only clock.
- s00_axis_areset  in  1: reset, synchronous, active-high.
- s00_axis_tvalid  in  1: input beat valid.
- s00_axis_tlast  in  1: last beat of the input packet.
- s00_axis_tdata  in  32: {angle, mag}.
- s00_axis_tstrb  in  4: ignored.
- s00_axis_tready  out  1: input accepted when high together with tvalid.
- squelch_threshold  in  16: unsigned; a sample with mag < threshold is squelched. Sampled on every accepted beat.
- m00_axis_tready  in  1: downstream ready.
- m00_axis_tvalid  out  1: output beat valid.
- m00_axis_tlast  out  1: output closes a packet.
- m00_axis_tdata  out  32: [15:0] signed audio, [16] squelch flag, [31:17] zero.
- m00_axis_tstrb  out  4: constant 4'hf.

## Operation
- **Accept.** A beat is accepted when s00_axis_tvalid && s00_axis_tready.
- **Ready.** s00_axis_tready = !s00_axis_areset && (!m00_axis_tvalid || m00_axis_tready).
- **Phase difference.**
  - dphi = angle − prev_angle, 16-bit modular subtraction read as signed. Wrap-around is therefore natural: 0x7F00→0x8100 gives +512.
  - If have_prev = 0 (first beat after reset or after a tlast), dphi = 0.
- **Per accepted beat:** prev_angle ← angle; have_prev ← 1.
- **Squelch.** If mag < squelch_threshold, dphi is forced to 0 and the group squelch flag is set. The sample still counts toward the group.
- **Accumulator.** acc is signed, 16+log2(C_DECIMATION) bits; dphi is sign-extended into it. count runs 0..C_DECIMATION−1.
- **Emit**, when count == C_DECIMATION−1 or the beat carries tlast:
  - audio = (acc + dphi) >>> log2(C_DECIMATION), arithmetic shift, low 16 bits.
  - Load the output register with audio, the squelch flag, and tlast = beat tlast; set tvalid.
  - Clear acc, count and the flag.
  - On tlast, also clear have_prev.
- **Partial groups.** A tlast-flushed group is not renormalised; the sum is still shifted by log2(C_DECIMATION).
- **Output hold.** The output register holds its data until m00_axis_tvalid && m00_axis_tready.
  - Emit and drain may happen in the same cycle, because ready permits it. The new beat then replaces the old one with no bubble.

## Timing
- **Reset values:** m00_axis_tvalid 0, m00_axis_tlast 0, m00_axis_tdata 0, s00_axis_tready 0. Internally, acc, count, prev_angle, have_prev and the de-emphasis state are all 0.
- **After reset:** s00_axis_tready rises in the first cycle after reset deasserts.
- **Latency:** m00_axis_tvalid is asserted on the clock edge that accepts the emitting beat, so it is visible one cycle after that beat is presented.
- **Throughput:** one input beat per cycle while downstream is ready; one output per C_DECIMATION inputs.
- **Backpressure:** while m00_axis_tvalid = 1 and m00_axis_tready = 0, s00_axis_tready = 0 and the output is stable. No input beat is lost.
- **Reset mid-group:** the partial accumulation is discarded. Any pending output is dropped (tvalid = 0 on the next cycle).
- **Simultaneous events:** tlast on the C_DECIMATIONth beat produces exactly one emission, with tlast = 1.

## Configuration
- **Macro:** FM_DEEMPH_EN.
- **When defined:** the emitted value passes through a first-order de-emphasis filter: y ← y + ((audio − y) >>> C_DEEMPH_SHIFT). The output is the new y.
  - y is reset to 0.
  - y is updated only on emission.
  - Latency is unchanged: the filter is computed combinationally before the output register.
- **When undefined:** raw decimated audio is output, and no filter state is synthesized.

## Structure
- **Package fm_demod_pkg:**
  - ANGLE_W = 16 and MAG_W = 16.
  - typedef angle_t (logic [15:0]) and audio_t (logic signed [15:0]).
  - The tdata bit-field positions of both streams (shared with the CORDIC consumer side).
- **Sub-module decim_accum:** the accumulate-and-dump counter/accumulator with a flush input. The top module holds the phase differencing, squelch, output register and handshake.

## Test plan
- **Constant step.** C_DECIMATION = 8, threshold 100, mag 1000, angles 0,1000,2000,… continuous → first output 875 (7000>>>3), all later outputs 1000, flag 0.
- **Wrap-around.** Angles alternate 0x7F00 / 0x8100 with C_DECIMATION = 1 → outputs +512, −512, +512, … with no glitch at ±32768.
- **Squelch.** mag 50, threshold 100, any angles → audio 0 and bit16 = 1. Raising mag to 200 on the next group → bit16 = 0.
- **Backpressure.** Hold m00_axis_tready low 5 cycles with an output pending → s00_axis_tready = 0 and tdata stable throughout. After release, every output matches the reference model.
- **Packet boundary.** tlast on the 3rd beat of a group (steps of 800 after the first beat) → emits (0+800+800)>>>3 = 200 with m00_axis_tlast = 1. The next beat's dphi is 0.
- **Reset mid-group.** s00_axis_areset for 1 cycle after 5 beats → no output; the next group starts fresh with a first dphi of 0. With FM_DEEMPH_EN, a 0→8000 step input gives outputs 1000, 1875, … (y += (x−y)>>>3).
